// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {StRun, StHold} state_e;

  // Register specifiers are zero-extended to this width before matching.
  localparam int unsigned RegMaxW = 32;
  localparam logic [RegMaxW-1:0] REG_ZERO = '0;

  function automatic logic reg_match(input logic use_src,
                                     input logic [RegMaxW-1:0] src,
                                     input logic [RegMaxW-1:0] dst);
    return use_src && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-in-ID hazard detection with a multi-cycle load stall,
// pipeline register enables, IF/ID flush and a stall-cycle counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_LAT     = 1,
  parameter bit          BRANCH_IN_ID = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_use_rs_i,
  input  logic              ifid_use_rt_i,
  input  logic              ifid_branch_i,
  input  logic              branch_taken_i,
  input  logic              idex_mem_read_i,
  input  logic              idex_reg_write_i,
  input  logic [REG_AW-1:0] idex_dst_i,
  input  logic              exmem_mem_read_i,
  input  logic [REG_AW-1:0] exmem_dst_i,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned RemW = $clog2(LOAD_LAT + 1);

  state_e          state_q, state_d;
  logic [RemW-1:0] rem_q, rem_d;
  logic            match_idex, match_exmem;
  logic            lu, br, stall;

  assign match_idex =
      reg_match(ifid_use_rs_i, RegMaxW'(ifid_rs_i), RegMaxW'(idex_dst_i)) |
      reg_match(ifid_use_rt_i, RegMaxW'(ifid_rt_i), RegMaxW'(idex_dst_i));
  assign match_exmem =
      reg_match(ifid_use_rs_i, RegMaxW'(ifid_rs_i), RegMaxW'(exmem_dst_i)) |
      reg_match(ifid_use_rt_i, RegMaxW'(ifid_rt_i), RegMaxW'(exmem_dst_i));

  assign lu = idex_mem_read_i & match_idex;
  assign br = BRANCH_IN_ID & ifid_branch_i &
              ((idex_reg_write_i & match_idex) | (exmem_mem_read_i & match_exmem));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        stall = lu | br;
        if (lu && (LOAD_LAT > 1)) begin
          rem_d   = RemW'(LOAD_LAT - 1);
          state_d = StHold;
        end
      end
      StHold: begin
        // ID/EX already holds the bubble, so inputs are not trusted here.
        stall = 1'b1;
        rem_d = rem_q - RemW'(1);
        if (rem_q == RemW'(1)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (rst_i) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign stall_o       = stall;
  assign pc_write_o    = ~stall;
  assign ifid_write_o  = ~stall;
  assign idex_bubble_o = stall;
  // A taken branch seen during a stall has stale operands; it re-resolves later.
  assign ifid_flush_o  = BRANCH_IN_ID & branch_taken_i & ~stall & ~rst_i;

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (1'b0),
    .inc_i  (stall),
    .count_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit across several parameterisations.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt, br, tk, imr, irw;
    logic [4:0] idst;
    logic       emr;
    logic [4:0] edst;
    logic       stall, flush;
  } vec_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs, rt, idst, edst;
  logic       urs, urt, br, tk, imr, irw, emr;

  logic        o_stall[4], o_pcw[4], o_ifw[4], o_bub[4], o_flush[4];
  logic [31:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  logic [1:0]  sel;
  logic [4:0]  obs_ctl;
  logic [31:0] obs_cnt;

  exp_t        sb[$];
  logic [31:0] cnt_exp = '0;
  logic [31:0] cnt_max = '1;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // dut 0: branch checks off; 1: LOAD_LAT=1; 2: LOAD_LAT=3; 3: LOAD_LAT=4, 4-bit counter
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_IN_ID(1'b0), .CNT_W(32)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_use_rs_i(urs),
    .ifid_use_rt_i(urt), .ifid_branch_i(br), .branch_taken_i(tk), .idex_mem_read_i(imr),
    .idex_reg_write_i(irw), .idex_dst_i(idst), .exmem_mem_read_i(emr), .exmem_dst_i(edst),
    .stall_o(o_stall[0]), .pc_write_o(o_pcw[0]), .ifid_write_o(o_ifw[0]),
    .idex_bubble_o(o_bub[0]), .ifid_flush_o(o_flush[0]), .stall_cnt_o(cnt0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_IN_ID(1'b1), .CNT_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_use_rs_i(urs),
    .ifid_use_rt_i(urt), .ifid_branch_i(br), .branch_taken_i(tk), .idex_mem_read_i(imr),
    .idex_reg_write_i(irw), .idex_dst_i(idst), .exmem_mem_read_i(emr), .exmem_dst_i(edst),
    .stall_o(o_stall[1]), .pc_write_o(o_pcw[1]), .ifid_write_o(o_ifw[1]),
    .idex_bubble_o(o_bub[1]), .ifid_flush_o(o_flush[1]), .stall_cnt_o(cnt1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .BRANCH_IN_ID(1'b1), .CNT_W(32)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_use_rs_i(urs),
    .ifid_use_rt_i(urt), .ifid_branch_i(br), .branch_taken_i(tk), .idex_mem_read_i(imr),
    .idex_reg_write_i(irw), .idex_dst_i(idst), .exmem_mem_read_i(emr), .exmem_dst_i(edst),
    .stall_o(o_stall[2]), .pc_write_o(o_pcw[2]), .ifid_write_o(o_ifw[2]),
    .idex_bubble_o(o_bub[2]), .ifid_flush_o(o_flush[2]), .stall_cnt_o(cnt2));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(4), .BRANCH_IN_ID(1'b1), .CNT_W(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_use_rs_i(urs),
    .ifid_use_rt_i(urt), .ifid_branch_i(br), .branch_taken_i(tk), .idex_mem_read_i(imr),
    .idex_reg_write_i(irw), .idex_dst_i(idst), .exmem_mem_read_i(emr), .exmem_dst_i(edst),
    .stall_o(o_stall[3]), .pc_write_o(o_pcw[3]), .ifid_write_o(o_ifw[3]),
    .idex_bubble_o(o_bub[3]), .ifid_flush_o(o_flush[3]), .stall_cnt_o(cnt3));

  always_comb begin
    obs_ctl = {o_stall[sel], o_pcw[sel], o_ifw[sel], o_bub[sel], o_flush[sel]};
    case (sel)
      2'd0:    obs_cnt = cnt0;
      2'd1:    obs_cnt = cnt1;
      2'd2:    obs_cnt = cnt2;
      default: obs_cnt = {28'd0, cnt3};
    endcase
  end

  function automatic vec_t v(input int a_rs, a_rt, a_urs, a_urt, a_br, a_tk, a_imr, a_irw,
                             a_idst, a_emr, a_edst, a_st, a_fl);
    vec_t r;
    r.rs = 5'(a_rs);     r.rt = 5'(a_rt);     r.urs = 1'(a_urs);  r.urt = 1'(a_urt);
    r.br = 1'(a_br);     r.tk = 1'(a_tk);     r.imr = 1'(a_imr);  r.irw = 1'(a_irw);
    r.idst = 5'(a_idst); r.emr = 1'(a_emr);   r.edst = 5'(a_edst);
    r.stall = 1'(a_st);  r.flush = 1'(a_fl);
    return r;
  endfunction

  task automatic drv(input vec_t s);
    rs = s.rs; rt = s.rt; urs = s.urs; urt = s.urt; br = s.br; tk = s.tk;
    imr = s.imr; irw = s.irw; idst = s.idst; emr = s.emr; edst = s.edst;
  endtask

  // Drive one cycle of stimulus and push what the DUT must show for it.
  task automatic apply(input vec_t s);
    @(posedge clk);
    #1;
    drv(s);
    sb.push_back('{s.stall, s.flush, cnt_exp});
    if (s.stall && (cnt_exp != cnt_max)) cnt_exp = cnt_exp + 32'd1;
  endtask

  task automatic do_reset();
    drv(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cnt_exp = '0;
  endtask

  task automatic test_reset();
    #1;
    rst = 1'b1;
    drv(v(2, 0, 1, 0, 1, 1, 1, 1, 2, 0, 0, 0, 0));
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {5'b01100, 32'd0}) begin
        $display("FAIL reset[dut%0d]: got ctl=%b cnt=%0d, want ctl=01100 cnt=0",
                 s, obs_ctl, obs_cnt);
      end else n_pass++;
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_load_use_lat1();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd1;
    seq = '{v(2, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL load_use_lat1[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_load_use_lat3();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd2;
    // Taken branch during HOLD must neither flush nor shorten the stall.
    seq = '{v(2, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0), v(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL load_use_lat3[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_reg_zero();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd1;
    seq = '{v(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), v(2, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0),
            v(4, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0), v(0, 3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 1, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL reg_zero[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_branch();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd1;
    seq = '{v(5, 0, 1, 0, 1, 0, 0, 1, 5, 0, 0, 1, 0), v(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0),
            v(5, 0, 1, 0, 1, 0, 1, 1, 5, 0, 0, 1, 0), v(5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 5, 1, 0),
            v(5, 0, 1, 0, 1, 1, 0, 0, 0, 0, 5, 0, 1), v(6, 0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL branch[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_flush();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd1;
    seq = '{v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), v(2, 0, 1, 0, 0, 1, 1, 1, 2, 0, 0, 1, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL flush[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_branch_disabled();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd0;
    seq = '{v(5, 0, 1, 0, 1, 1, 0, 1, 5, 0, 0, 0, 0), v(5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0),
            v(2, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL branch_disabled[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd3;
    seq = '{v(2, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
            v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL mid_hold_pre[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
    // Second HOLD cycle: reset must end the stall without waiting for a clock.
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({obs_ctl, obs_cnt} !== {5'b01100, 32'd0}) begin
      $display("FAIL mid_hold_reset: got ctl=%b cnt=%0d, want ctl=01100 cnt=0", obs_ctl, obs_cnt);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cnt_exp = '0;
    seq = '{v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL mid_hold_post[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
  endtask

  task automatic test_saturation();
    vec_t seq[$];
    exp_t e;
    do_reset();
    sel = 2'd3;
    cnt_max = 32'd15;
    for (int k = 0; k < 20; k++) seq.push_back(v(2, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl, obs_cnt} !== {e.stall, ~e.stall, ~e.stall, e.stall, e.flush, e.cnt}) begin
        $display("FAIL saturation[%0d]: got ctl=%b cnt=%0d, want stall=%b flush=%b cnt=%0d",
                 i, obs_ctl, obs_cnt, e.stall, e.flush, e.cnt);
      end else n_pass++;
    end
    cnt_max = '1;
  endtask

  initial begin
    sel = 2'd0;
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3();
    test_reg_zero();
    test_branch();
    test_flush();
    test_branch_disabled();
    test_reset_mid_hold();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
